// File: rtl/sum_result_buffer_if.sv
// sum_result_buffer_if
//   Bundles the credit, adder-result and consumer-side signals of
//   sum_result_buffer. Clock and reset stay plain ports on the module.
//
//   master : the buffer itself (drives credit, head result, status)
//   slave  : the surrounding system (issue logic, adder output, consumer)
//
//   issue_req  upstream wants to launch an add this cycle
//   issue_ok   credit available; an add launches iff issue_req & issue_ok
//   add_v      adder result valid
//   add_sum    adder result
//   m_valid    result available at FIFO head
//   m_data     head result
//   m_ready    consumer accepts head
//   occupancy  entries stored in the FIFO
//   err        sticky protocol error
interface sum_result_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             issue_req;
  logic             issue_ok;
  logic             add_v;
  logic [WIDTH-1:0] add_sum;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [CW-1:0]    occupancy;
  logic             err;

  modport master (
    input  issue_req, add_v, add_sum, m_ready,
    output issue_ok, m_valid, m_data, occupancy, err
  );

  modport slave (
    output issue_req, add_v, add_sum, m_ready,
    input  issue_ok, m_valid, m_data, occupancy, err
  );
endinterface

// File: rtl/sum_result_buffer.sv
// sum_result_buffer
//   Captures every result pulse from the fixed-latency pipelined adder into
//   a small FIFO and presents it on a valid/ready interface. Credits are
//   handed upstream so an add is only launched when its result is
//   guaranteed a slot. After reset a drain window of LATENCY cycles drops
//   results that were already travelling through the adder.
//
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sum_result_buffer_if.master (credit, adder result, consumer side)
//
//   LATENCY must be at least 1; DEPTH is a power of two.
//
//   state | meaning
//   DRAIN | post-reset window; no credit, add_v ignored, drain_cnt counts down
//   RUN   | normal operation; left only through rst
module sum_result_buffer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 5
) (
  input logic               clk,
  input logic               rst,
  sum_result_buffer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {ST_DRAIN, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    rsv_q, rsv_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic run, full, issue_ok, issue, pop, push, overflow, orphan;

  // Control FSM: DRAIN lasts exactly LATENCY cycles after reset.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (state_q == ST_DRAIN) begin
      drain_cnt_d = drain_cnt_q - DW'(1);
      if (drain_cnt_q == DW'(1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    run      = (state_q == ST_RUN);
    full     = (occ_q == DEPTH_C);
    issue_ok = run && (rsv_q < DEPTH_C);
    issue    = bus.issue_req && issue_ok;
    pop      = (occ_q != '0) && bus.m_ready;
    push     = run && bus.add_v && (!full || pop);
    overflow = run && bus.add_v && full && !pop;
    // A result with nothing in flight means upstream bypassed the credits.
    orphan   = run && bus.add_v && (rsv_q == occ_q);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    occ_d    = occ_q + CW'(push) - CW'(pop);
    err_d    = err_q || overflow || orphan;

    // Words pushed without a credit can make pops outnumber reservations;
    // hold at zero rather than wrap and lock out all further issues.
    rsv_d = rsv_q;
    if (issue && !pop) begin
      rsv_d = rsv_q + CW'(1);
    end else if (!issue && pop && (rsv_q != '0)) begin
      rsv_d = rsv_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DRAIN;
      drain_cnt_q <= DW'(LATENCY);
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      rsv_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      rsv_q       <= rsv_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= bus.add_sum;
    end
  end

  assign bus.issue_ok  = issue_ok;
  assign bus.m_valid   = (occ_q != '0);
  assign bus.m_data    = mem_q[rd_ptr_q];
  assign bus.occupancy = occ_q;
  assign bus.err       = err_q;
endmodule

// File: doc/sum_result_buffer.md
# sum_result_buffer

Result-side buffer that sits directly downstream of the pipelined adder (IOB-wrapped, fixed latency, no backpressure). It captures every `v_out`/`sum` pulse into a small FIFO and presents results on a valid/ready interface. It issues credits upstream so the adder is never fed an operand whose result could not be stored. A post-reset drain window discards stale results still travelling through the adder pipeline.

## Interface
- `WIDTH`, 32, result width; equals the adder `WIDTH`.
- `DEPTH`, 8, FIFO entries; power of two, 2..16.
- `LATENCY`, 5, adder cycles from `v_in` to `v_out` (1 input IOB + 3 core + 1 output IOB); drain window length.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `issue_req`  in  1  upstream wants to launch an add this cycle.
- `issue_ok`  out  1  credit available; an add is launched iff `issue_req & issue_ok`.
- `add_v`  in  1  adder result valid.
- `add_sum`  in  WIDTH  adder result.
- `m_valid`  out  1  result available at head of FIFO.
- `m_data`  out  WIDTH  head result.
- `m_ready`  in  1  consumer accepts head.
- `occupancy`  out  $clog2(DEPTH+1)  entries stored in FIFO.
- `err`  out  1  sticky protocol error; cleared only by `rst`.

## Operation
- State registers:
  - `wr_ptr`, `rd_ptr`: $clog2(DEPTH) bits, wrap modulo DEPTH.
  - `occupancy`.
  - `reserved`: $clog2(DEPTH+1) bits; counts FIFO entries plus in-flight adds.
  - `drain_cnt`: counts LATENCY down to 0.
  - `err`.
- Two-state control FSM:
  - DRAIN: entered on `rst`; `drain_cnt` loaded with LATENCY. `issue_ok`=0 and `add_v` is ignored (no push, no error). `drain_cnt` decrements each cycle. Move to RUN when `drain_cnt` reaches 1 → 0, i.e. after exactly LATENCY cycles of DRAIN.
  - RUN: normal operation. No exit except `rst`.
- Issue: `issue_ok` = RUN & (`reserved` < DEPTH). Combinational from registers only; no dependence on `issue_req`.
- Push (RUN only): `add_v`=1 writes `add_sum` at `wr_ptr` and advances `wr_ptr`. Push is accepted if `occupancy` < DEPTH or a pop happens in the same cycle.
- Pop: `m_valid` = (`occupancy` != 0). `m_data` = mem[`rd_ptr`], asynchronous read. On `m_valid & m_ready`, `rd_ptr` advances.
- `occupancy` next = occupancy + push − pop.
- `reserved` next = reserved + issue − pop, where issue = `issue_req & issue_ok`. Issue and pop in the same cycle leave it unchanged. `reserved` never exceeds DEPTH.
- Errors, in RUN only; `err` is set and stays set:
  - Push while FIFO full and no pop. The word is dropped; pointers and occupancy are unchanged.
  - `add_v` while `reserved` == `occupancy` (no add in flight). The word is still pushed if space exists.
- Upstream must gate the adder's `v_in` with `issue_req & issue_ok` only.

## Timing
- Reset values:
  - `issue_ok`=0, `m_valid`=0, `occupancy`=0, `err`=0.
  - `m_data` undefined/don't-care while `m_valid`=0.
  - All pointers and counters 0; FSM in DRAIN with `drain_cnt`=LATENCY.
- First `issue_ok`=1 occurs on cycle LATENCY after the last cycle with `rst`=1. The cycle after `rst` falls is cycle 0.
- Push-to-visible latency: `add_v` sampled at edge t → `m_valid`=1 and `m_data` valid after edge t, i.e. 1 cycle. No fall-through in the same cycle.
- Issue-to-result (system): adder `v_in` at edge t → `add_v` at t+LATENCY → `m_valid` at t+LATENCY+1.
- Credit return: a pop at edge t raises `issue_ok` (if it was limited by `reserved`) in cycle t+1.
- Full plus simultaneous pop and push: both happen, `occupancy` stays DEPTH, no error.
- Empty plus push with `m_ready`=1: no pop that cycle, because `m_valid` was 0.
- `rst` mid-operation:
  - All contents and credits are discarded.
  - Up to LATENCY stale `add_v` pulses are absorbed silently in DRAIN.
  - `rst` asserted during DRAIN restarts the count.
- Throughput: 1 result/cycle sustained when `m_ready`=1 continuously and DEPTH ≥ LATENCY+1.

## Test plan
- Reset/drain: hold `rst` 3 cycles, release, pulse `add_v` with `add_sum`=0xDEADBEEF on drain cycles 0 and 4. Required: `issue_ok`=0 for cycles 0..4 and 1 at cycle 5; `m_valid`=0 throughout; `err`=0.
- Credit limit (DEPTH=8, `m_ready`=0): hold `issue_req`=1 with a LATENCY-5 adder model computing a+b. Required: exactly 8 issues, then `issue_ok`=0. After the 8 results, `occupancy`=8 and `m_valid`=1; the first result is 1+2=0x00000003.
- Credit return: from the full state, assert `m_ready` for 1 cycle. Required: `occupancy`=7, `issue_ok`=1 on the next cycle, exactly 1 further issue, then `issue_ok`=0.
- Streaming: 100 back-to-back issues with `m_ready`=1 and random `a`/`b`. Required: outputs in issue order, sum = (a+b+cin) mod 2^32 including 0xFFFFFFFF+0x00000001=0x00000000, no gaps after the first, `err`=0, and `wr_ptr` wraps 12+ times.
- Protocol errors:
  - Inject `add_v` with nothing in flight. Required: `err`=1 next cycle and the word is stored.
  - Then force a push into a full FIFO with `m_ready`=0. Required: the word is dropped, `occupancy` stays 8, `err` stays 1.
- Reset mid-stream: with 4 adds in flight and 3 stored, assert `rst` 1 cycle. Required: `occupancy`=0, `m_valid`=0 next cycle, stale results dropped, `err`=0, and `issue_ok` returns LATENCY cycles later.
